// File: rtl/vector_instr_queue.sv
// Vector instruction queue: circular FIFO of {instr, rs1, rs2} between the scalar core and the vector scheduler.
// Optional empty-queue bypass is enabled by defining VIQ_BYPASS_EN.
module vector_instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_vld_i,
  input  logic [31:0]                vector_instr_i,
  input  logic [31:0]                rs1_i,
  input  logic [31:0]                rs2_i,
  output logic                       vector_stall_o,
  input  logic                       sched_stall_i,
  output logic [31:0]                vector_instr_o,
  output logic [31:0]                scalar_rs1_o,
  output logic [31:0]                scalar_rs2_o,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   rs1_mem   [DEPTH];
  logic [31:0]   rs2_mem   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          bypass;
  logic          push;
  logic          pop;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

`ifdef VIQ_BYPASS_EN
  // Empty queue with a ready scheduler: hand the input straight through, nothing is stored.
  assign bypass = empty && instr_vld_i && !sched_stall_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = instr_vld_i && !full && !flush_i && !bypass;
  assign pop  = !empty && !sched_stall_i && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem[wr_ptr] <= vector_instr_i;
      rs1_mem[wr_ptr]   <= rs1_i;
      rs2_mem[wr_ptr]   <= rs2_i;
    end
  end

`ifdef VIQ_BYPASS_EN
  always_comb begin
    vector_instr_o = 32'h0;
    scalar_rs1_o   = 32'h0;
    scalar_rs2_o   = 32'h0;
    if (bypass) begin
      vector_instr_o = vector_instr_i;
      scalar_rs1_o   = rs1_i;
      scalar_rs2_o   = rs2_i;
    end else if (!empty) begin
      vector_instr_o = instr_mem[rd_ptr];
      scalar_rs1_o   = rs1_mem[rd_ptr];
      scalar_rs2_o   = rs2_mem[rd_ptr];
    end
  end
`else
  always_comb begin
    vector_instr_o = 32'h0;
    scalar_rs1_o   = 32'h0;
    scalar_rs2_o   = 32'h0;
    if (!empty) begin
      vector_instr_o = instr_mem[rd_ptr];
      scalar_rs1_o   = rs1_mem[rd_ptr];
      scalar_rs2_o   = rs2_mem[rd_ptr];
    end
  end
`endif

  assign vector_stall_o = full;
  assign count_o        = count;
  assign empty_o        = empty;

endmodule

// File: tb/tb_vector_instr_queue.sv
// Directed bench for vector_instr_queue (DEPTH=4) with a reference occupancy model and an expected-entry scoreboard.
module tb_vector_instr_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_vld_i;
  logic [31:0] vector_instr_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        vector_stall_o;
  logic        sched_stall_i;
  logic [31:0] vector_instr_o;
  logic [31:0] scalar_rs1_o;
  logic [31:0] scalar_rs2_o;
  logic        flush_i;
  logic [2:0]  count_o;
  logic        empty_o;

  int n_checks = 0;
  int n_fail   = 0;
  int model_count = 0;
  logic [95:0] sb[$];

  vector_instr_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .instr_vld_i(instr_vld_i), .vector_instr_i(vector_instr_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i),
    .vector_stall_o(vector_stall_o), .sched_stall_i(sched_stall_i),
    .vector_instr_o(vector_instr_o), .scalar_rs1_o(scalar_rs1_o),
    .scalar_rs2_o(scalar_rs2_o), .flush_i(flush_i),
    .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model mid-cycle, then advance the model.
  task automatic cycle(input logic vld, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic stall, input logic flush);
    logic byp, psh, pp;
    logic [95:0] head;
    instr_vld_i    = vld;
    vector_instr_i = ins;
    rs1_i          = r1;
    rs2_i          = r2;
    sched_stall_i  = stall;
    flush_i        = flush;
`ifdef VIQ_BYPASS_EN
    byp = (model_count == 0) && vld && !stall && !flush;
`else
    byp = 1'b0;
`endif
    psh = vld && (model_count < 4) && !flush && !byp;
    pp  = (model_count > 0) && !stall && !flush;
    head = byp ? {ins, r1, r2} : (model_count > 0 ? sb[0] : 96'h0);
    #4;
    chk("count",  32'(count_o), 32'(model_count));
    chk("empty",  32'(empty_o), 32'(model_count == 0));
    chk("stall",  32'(vector_stall_o), 32'(model_count == 4));
    chk("instr",  vector_instr_o, head[95:64]);
    chk("rs1",    scalar_rs1_o, head[63:32]);
    chk("rs2",    scalar_rs2_o, head[31:0]);
    @(posedge clk);
    #1;
    if (flush) begin
      sb.delete();
      model_count = 0;
    end else begin
      if (pp) void'(sb.pop_front());
      if (psh) sb.push_back({ins, r1, r2});
      model_count = model_count + (psh ? 1 : 0) - (pp ? 1 : 0);
    end
  endtask

  task automatic do_reset(input logic vld);
    rst = 1'b1;
    instr_vld_i = vld;
    vector_instr_i = 32'hDEAD_0001;
    sched_stall_i = 1'b0;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush_i = 1'b0;
    instr_vld_i = 1'b0;
    sb.delete();
    model_count = 0;
  endtask

  initial begin
    rst = 1'b1; instr_vld_i = 1'b0; vector_instr_i = '0; rs1_i = '0; rs2_i = '0;
    sched_stall_i = 1'b0; flush_i = 1'b0;
    @(posedge clk); #1;
    do_reset(1'b0);

    // Idle after reset
    cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);
    cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Single push into empty queue, then drain
    cycle(1, 32'h0200_7007, 32'h1000, 32'h0, 0, 0);
    cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);
    cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Fill under scheduler stall, over-push, then release
    for (int i = 0; i < 4; i++)
      cycle(1, 32'hA000_0000 + 32'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 1, 0);
    cycle(1, 32'hE000_0000, 32'h1EE, 32'h2EE, 1, 0);
    cycle(1, 32'hE000_0000, 32'h1EE, 32'h2EE, 1, 0);
    cycle(1, 32'hE000_0000, 32'h1EE, 32'h2EE, 0, 0);
    cycle(1, 32'hE000_0000, 32'h1EE, 32'h2EE, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Steady push+pop at count=2 across several pointer wraps
    cycle(1, 32'hB000_0000, 32'h300, 32'h400, 1, 0);
    cycle(1, 32'hB000_0001, 32'h301, 32'h401, 1, 0);
    for (int i = 2; i < 14; i++)
      cycle(1, 32'hB000_0000 + 32'(i), 32'h300 + 32'(i), 32'h400 + 32'(i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Flush at count=3 with a concurrent push
    for (int i = 0; i < 3; i++)
      cycle(1, 32'hC000_0000 + 32'(i), 32'h500 + 32'(i), 32'h600 + 32'(i), 1, 0);
    cycle(1, 32'hC0FF_EE00, 32'h5FF, 32'h6FF, 0, 1);
    cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);
    cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Reset mid-stream at count=3, with a push, pop and flush all requested
    for (int i = 0; i < 3; i++)
      cycle(1, 32'hD000_0000 + 32'(i), 32'h700 + 32'(i), 32'h800 + 32'(i), 1, 0);
    do_reset(1'b1);
    cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Push into empty queue without stall, then with stall
    cycle(1, 32'hF000_0001, 32'h901, 32'hA01, 0, 0);
    cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);
    cycle(1, 32'hF000_0002, 32'h902, 32'hA02, 1, 0);
    cycle(0, 32'h0, 32'h0, 32'h0, 1, 0);
    cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);
    cycle(0, 32'h0, 32'h0, 32'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_instr_queue.md
VECTOR_INSTR_QUEUE -- requirements
Module: vector_instr_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, >= 2.
REQ-002 Ports, clock and reset first:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- instr_vld_i  in  1  scalar core presents a vector instruction this cycle.
- vector_instr_i  in  32  vector instruction from the scalar core.
- rs1_i  in  32  scalar rs1 operand value.
- rs2_i  in  32  scalar rs2 operand value.
- vector_stall_o  out  1  queue full; the scalar core shall hold its instruction.
- sched_stall_i  in  1  scheduler stall; the output entry is not consumed this cycle.
- vector_instr_o  out  32  head instruction to the scheduler; 32'h0 when empty.
- scalar_rs1_o  out  32  head rs1; 32'h0 when empty.
- scalar_rs2_o  out  32  head rs2; 32'h0 when empty.
- flush_i  in  1  discard all entries.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.
- empty_o  out  1  count_o == 0.

Function
REQ-003 Each entry SHALL store {instr[31:0], rs1[31:0], rs2[31:0]}; the queue is circular, with write pointer wr_ptr, read pointer rd_ptr and occupancy count.
REQ-004 vector_stall_o SHALL equal (count == DEPTH), a function of registered state only.
REQ-005 A push SHALL occur when instr_vld_i && !vector_stall_o && !flush_i; the entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-006 A pop SHALL occur when !empty && !sched_stall_i && !flush_i; rd_ptr increments modulo DEPTH.
REQ-007 A push and a pop in the same cycle SHALL leave count unchanged; push alone increments it; pop alone decrements it.
REQ-008 instr_vld_i while full SHALL be ignored. The core holds the instruction under vector_stall_o, so nothing is lost.
REQ-009 Outputs SHALL present the entry at rd_ptr combinationally from storage. When empty, outputs SHALL be all-zero; opcode 0 is treated as no instruction downstream.
REQ-010 When sched_stall_i is high, the head entry and all outputs SHALL stay stable.
REQ-011 Entries SHALL leave in push order; the per-entry pairing of instruction and rs1/rs2 SHALL be preserved.
REQ-012 flush_i SHALL reset wr_ptr, rd_ptr and count to 0 at the next edge; a push or pop in the same cycle is discarded.
REQ-013 Latency without bypass: an instruction pushed into an empty queue SHALL appear on the outputs one cycle after acceptance.
REQ-014 count_o and empty_o SHALL reflect registered state.

Reset
REQ-015 While rst is high at a clock edge: pointers and count SHALL become 0, so vector_stall_o=0, empty_o=1, count_o=0, and vector_instr_o, scalar_rs1_o and scalar_rs2_o are 0.
REQ-016 Reset mid-operation SHALL discard all entries; storage contents need not be cleared.
REQ-017 Reset SHALL take priority over flush_i, push and pop.

Configuration
REQ-018 Macro VIQ_BYPASS_EN controls empty-queue bypass.
- Defined: when the queue is empty, instr_vld_i=1, sched_stall_i=0 and flush_i=0, the input SHALL drive the outputs combinationally in the same cycle and no entry is written; count stays 0. When the queue is empty but sched_stall_i=1, the input SHALL be written normally.
- Defined, empty_o: SHALL remain registered-state based.
- Undefined: outputs SHALL come only from storage (REQ-013), with no combinational path from the input ports to vector_instr_o, scalar_rs1_o or scalar_rs2_o.

Verification
REQ-019 The bench SHALL cover these directed scenarios (DEPTH=4):
- Reset, then idle -> vector_instr_o=0, count_o=0, empty_o=1, vector_stall_o=0.
- Push instr 32'h0200_7007, rs1=32'h1000 with sched_stall_i=0, bypass off -> outputs show that entry one cycle later, then return to 0; count_o goes 1 then 0.
- sched_stall_i=1, push 4 entries A,B,C,D -> count_o=4, vector_stall_o=1; a 5th push E is ignored; release the stall -> A,B,C,D appear one per cycle in order, and E is accepted once vector_stall_o drops.
- Simultaneous push and pop at count=2 -> count_o stays 2; order is preserved across pointer wrap over 10 or more entries.
- flush_i at count=3 with concurrent instr_vld_i -> next cycle count_o=0, outputs 0, no entry written.
- rst asserted at count=3 mid-stream -> next cycle count_o=0, empty_o=1. With VIQ_BYPASS_EN, a push into an empty queue with no stall -> the same-cycle output equals the input and count_o stays 0.
